// File: rtl/laser310_ram64k_ctrl.sv
// Laser 310 / VZ300 64 KB SRAM expansion decoder.
// Maps B800H-FFFFH onto the SRAM and banks the C000H-FFFFH window through an I/O-port register.
module laser310_ram64k_ctrl #(
    parameter logic [3:0] BANK_PORT  = 4'b0111,
    parameter logic [1:0] BANK_RESET = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Addr,
    input  logic [3:0] AddrIO,
    input  logic       WR_N,
    input  logic       RD_N,
    input  logic       MREQ_N,
    input  logic       IORQ_N,
    input  logic [1:0] D1D0,
    output logic [1:0] RAM_A1514,
    output logic       RAM_CS_N,
    output logic       RAM_OE_N,
    output logic       RAM_WE_N,
    output logic       led1,
    output logic       led2
);

    // Bank 00 is reserved for the B800H window, so a request for it selects bank 01.
    function automatic logic [1:0] map_bank(input logic [1:0] d);
        logic [1:0] m;
        case (d)
            2'b00:   m = 2'b01;
            2'b01:   m = 2'b01;
            2'b10:   m = 2'b10;
            2'b11:   m = 2'b11;
            default: m = 2'b01;
        endcase
        return m;
    endfunction

    logic [1:0] bank_r;
    logic       mem_cyc_s;
    logic       win_lo_s;
    logic       win_hi_s;
    logic       sel_s;
    logic       io_wr_s;

    // Bus-cycle classification and window decode.
    always_comb begin
        mem_cyc_s = 1'b0;
        win_lo_s  = 1'b0;
        win_hi_s  = 1'b0;
        io_wr_s   = 1'b0;
        if (!MREQ_N && IORQ_N && (RD_N ^ WR_N)) begin
            mem_cyc_s = 1'b1;
        end else begin
            mem_cyc_s = 1'b0;
        end
        if (Addr == 5'b10111) begin
            win_lo_s = 1'b1;
        end else begin
            win_lo_s = 1'b0;
        end
        if (Addr[4:3] == 2'b11) begin
            win_hi_s = 1'b1;
        end else begin
            win_hi_s = 1'b0;
        end
        if (!IORQ_N && MREQ_N && !WR_N && RD_N && (AddrIO == BANK_PORT)) begin
            io_wr_s = 1'b1;
        end else begin
            io_wr_s = 1'b0;
        end
    end

    assign sel_s = mem_cyc_s & (win_lo_s | win_hi_s);

    // SRAM strobes and upper address; the bank bits follow Addr regardless of strobes.
    always_comb begin
        RAM_CS_N  = 1'b1;
        RAM_OE_N  = 1'b1;
        RAM_WE_N  = 1'b1;
        RAM_A1514 = 2'b00;
        if (sel_s) begin
            RAM_CS_N = 1'b0;
            RAM_OE_N = RD_N;
            RAM_WE_N = WR_N;
        end else begin
            RAM_CS_N = 1'b1;
            RAM_OE_N = 1'b1;
            RAM_WE_N = 1'b1;
        end
        if (win_hi_s) begin
            RAM_A1514 = bank_r;
        end else begin
            RAM_A1514 = 2'b00;
        end
    end

    // Status LEDs: SRAM activity and non-default bank.
    always_comb begin
        led1 = 1'b0;
        led2 = 1'b0;
        led1 = sel_s;
        if (bank_r != 2'b01) begin
            led2 = 1'b1;
        end else begin
            led2 = 1'b0;
        end
    end

    // Bank register; reloading during a long I/O write just rewrites the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r <= BANK_RESET;
        end else if (io_wr_s) begin
            bank_r <= map_bank(D1D0);
        end else begin
            bank_r <= bank_r;
        end
    end

endmodule

// File: tb/tb_laser310_ram64k_ctrl.sv
// Self-checking bench for laser310_ram64k_ctrl: directed scenarios then randomized bus
// cycles, all compared against an address-arithmetic reference model.
module tb_laser310_ram64k_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Addr;
    logic [3:0] AddrIO;
    logic       WR_N;
    logic       RD_N;
    logic       MREQ_N;
    logic       IORQ_N;
    logic [1:0] D1D0;
    logic [1:0] RAM_A1514;
    logic       RAM_CS_N;
    logic       RAM_OE_N;
    logic       RAM_WE_N;
    logic       led1;
    logic       led2;

    int checks = 0;
    int errors = 0;
    int bank_m = 1;

    laser310_ram64k_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .AddrIO(AddrIO), .WR_N(WR_N), .RD_N(RD_N),
        .MREQ_N(MREQ_N), .IORQ_N(IORQ_N), .D1D0(D1D0), .RAM_A1514(RAM_A1514),
        .RAM_CS_N(RAM_CS_N), .RAM_OE_N(RAM_OE_N), .RAM_WE_N(RAM_WE_N),
        .led1(led1), .led2(led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: full 16-bit base address of the 2 KB block, compared against window limits.
    task automatic check_all(input string tag);
        int  base;
        bit  mem;
        bit  sel;
        base = int'(Addr) * 2048;
        mem  = (MREQ_N == 1'b0) && (IORQ_N == 1'b1) && (RD_N != WR_N);
        sel  = mem && (base >= 32'hB800);
        chk({tag, ".cs"},   int'(RAM_CS_N),  sel ? 0 : 1);
        chk({tag, ".oe"},   int'(RAM_OE_N),  (sel && RD_N == 1'b0) ? 0 : 1);
        chk({tag, ".we"},   int'(RAM_WE_N),  (sel && WR_N == 1'b0) ? 0 : 1);
        chk({tag, ".a1514"}, int'(RAM_A1514), (base >= 32'hC000) ? bank_m : 0);
        chk({tag, ".led1"}, int'(led1),      sel ? 1 : 0);
        chk({tag, ".led2"}, int'(led2),      (bank_m != 1) ? 1 : 0);
    endtask

    // Drive one bus state, check it, clock it in, update the model, check again.
    task automatic apply(input string tag, input logic [4:0] a, input logic [3:0] aio,
                         input logic wr, input logic rd, input logic mreq,
                         input logic iorq, input logic [1:0] d);
        int port;
        Addr = a; AddrIO = aio; WR_N = wr; RD_N = rd; MREQ_N = mreq; IORQ_N = iorq; D1D0 = d;
        #1;
        check_all({tag, ".pre"});
        @(posedge clk);
        port = int'(aio) * 16;
        if (iorq == 1'b0 && mreq == 1'b1 && wr == 1'b0 && rd == 1'b1 &&
            port >= 32'h70 && port <= 32'h7F) begin
            bank_m = (d == 2'b00) ? 1 : int'(d);
        end
        #1;
        check_all({tag, ".post"});
    endtask

    task automatic mem_rd(input string tag, input logic [4:0] a);
        apply(tag, a, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    endtask

    task automatic io_wr(input string tag, input logic [3:0] aio, input logic [1:0] d);
        apply(tag, aio == 4'b0111 ? 5'b11000 : 5'b11000, aio, 1'b0, 1'b1, 1'b1, 1'b0, d);
    endtask

    initial begin
        rst = 1'b1;
        Addr = 5'b00000; AddrIO = 4'b0000; WR_N = 1'b1; RD_N = 1'b1;
        MREQ_N = 1'b1; IORQ_N = 1'b1; D1D0 = 2'b00;
        #12;
        check_all("reset_idle");
        chk("reset_led2", int'(led2), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Strobe combinations that are not memory cycles.
        apply("t1_rdwr11", 5'b11000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        apply("t1_rdwr00", 5'b11000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        apply("t2_req11",  5'b11000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        apply("t2_req00",  5'b11000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

        // B800H window write and read.
        apply("t3_wr", 5'b10111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        chk("t3_wr_we", int'(RAM_WE_N), 0);
        mem_rd("t3_rd", 5'b10111);
        chk("t3_rd_oe", int'(RAM_OE_N), 0);

        // Window edges.
        mem_rd("t4_b7", 5'b10110);
        chk("t4_b7_cs", int'(RAM_CS_N), 1);
        mem_rd("t4_c0", 5'b11000);
        chk("t4_c0_a", int'(RAM_A1514), 1);
        mem_rd("t4_f8", 5'b11111);
        mem_rd("t4_b8", 5'b10111);

        // Bank switching, including 00 remapped to 01.
        io_wr("t5_io10", 4'b0111, 2'b10);
        mem_rd("t5_c0_10", 5'b11000);
        chk("t5_a_10", int'(RAM_A1514), 2);
        mem_rd("t5_b8_10", 5'b10111);
        io_wr("t5_io11", 4'b0111, 2'b11);
        mem_rd("t5_c0_11", 5'b11000);
        chk("t5_a_11", int'(RAM_A1514), 3);
        io_wr("t5_io00", 4'b0111, 2'b00);
        mem_rd("t5_c0_00", 5'b11000);
        chk("t5_a_00", int'(RAM_A1514), 1);
        chk("t5_led2_00", int'(led2), 0);

        // Asynchronous reset mid-cycle, then a write to a non-matching port.
        io_wr("t6_io11", 4'b0111, 2'b11);
        Addr = 5'b11000; AddrIO = 4'h0; WR_N = 1'b1; RD_N = 1'b0; MREQ_N = 1'b0; IORQ_N = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        bank_m = 1;
        #1;
        check_all("t6_rst");
        chk("t6_rst_a", int'(RAM_A1514), 1);
        #2;
        rst = 1'b0;
        io_wr("t6_io_port6", 4'b0110, 2'b11);
        mem_rd("t6_c0", 5'b11000);
        chk("t6_c0_a", int'(RAM_A1514), 1);

        // Randomized bus states, biased toward valid cycles and the bank port.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ra;
            logic [3:0] rio;
            logic rw, rr, rm, ri;
            logic [1:0] rd2;
            int kind;
            ra   = 5'($urandom_range(31, 0));
            rd2  = 2'($urandom_range(3, 0));
            kind = $urandom_range(3, 0);
            rio  = ($urandom_range(1, 0) == 1) ? 4'b0111 : 4'($urandom_range(15, 0));
            case (kind)
                0: begin rm = 1'b0; ri = 1'b1; rr = 1'b0; rw = 1'b1; end
                1: begin rm = 1'b0; ri = 1'b1; rr = 1'b1; rw = 1'b0; end
                2: begin rm = 1'b1; ri = 1'b0; rr = 1'b1; rw = 1'b0; end
                default: begin
                    rm = 1'($urandom_range(1, 0)); ri = 1'($urandom_range(1, 0));
                    rr = 1'($urandom_range(1, 0)); rw = 1'($urandom_range(1, 0));
                end
            endcase
            apply("rand", ra, rio, rw, rr, rm, ri, rd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
